// File: rtl/aq_axilm_bridge_if.sv
// AXI4-Lite channel bundle between the register-request bridge (master) and a register slave.
interface aq_axilm_bridge_if #(
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] awaddr;
   logic [3:0]        awcache;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;

   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;

   logic              bvalid;
   logic [1:0]        bresp;
   logic              bready;

   logic [ADDR_W-1:0] araddr;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;

   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awcache, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bvalid, bresp, output bready,
      output araddr, arcache, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awcache, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bvalid, bresp, input bready,
      input  araddr, arcache, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/aq_axilm_bridge.sv
// Single-outstanding AXI4-Lite master: converts one local register request into a write or read burst-free transaction.
module aq_axilm_bridge #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              LOCAL_REQ,
   input  logic              LOCAL_RNW,
   input  logic [ADDR_W-1:0] LOCAL_ADDR,
   input  logic [3:0]        LOCAL_BE,
   input  logic [31:0]       LOCAL_WDATA,
   output logic              LOCAL_BUSY,
   output logic              LOCAL_ACK,
   output logic [31:0]       LOCAL_RDATA,
   output logic [1:0]        LOCAL_RESP,
   aq_axilm_bridge_if.master m_axi
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WADDR = 3'd1,
      ST_WRESP = 3'd2,
      ST_RADDR = 3'd3,
      ST_RDATA = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   strb_q, strb_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic                busy_q, busy_d;
   logic                ack_q, ack_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          resp_q, resp_d;

   // State and all channel/local outputs are registered together.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      ack_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (LOCAL_REQ) begin
               addr_d    = LOCAL_ADDR;
               wdata_d   = LOCAL_WDATA;
               strb_d    = LOCAL_BE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = LOCAL_RNW ? ST_RADDR : ST_WADDR;
            end
         end
         ST_WADDR: begin
            // AW and W complete independently; a handshake this cycle already counts.
            if (awvalid_q && m_axi.awready) aw_done_d = 1'b1;
            if (wvalid_q && m_axi.wready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)      state_d   = ST_WRESP;
         end
         ST_WRESP: begin
            if (m_axi.bvalid) begin
               resp_d  = m_axi.bresp;
               ack_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_RADDR: begin
            if (m_axi.arready) state_d = ST_RDATA;
         end
         ST_RDATA: begin
            if (m_axi.rvalid) begin
               rdata_d = m_axi.rdata;
               resp_d  = m_axi.rresp;
               ack_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Handshake outputs follow the state being entered so they are flop outputs.
      awvalid_d = (state_d == ST_WADDR) && !aw_done_d;
      wvalid_d  = (state_d == ST_WADDR) && !w_done_d;
      bready_d  = (state_d == ST_WRESP);
      arvalid_d = (state_d == ST_RADDR);
      rready_d  = (state_d == ST_RDATA);
      busy_d    = (state_d != ST_IDLE);
   end

   assign m_axi.awaddr  = addr_q;
   assign m_axi.awcache = 4'b0011;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = strb_q;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arcache = 4'b0011;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;

   assign LOCAL_BUSY  = busy_q;
   assign LOCAL_ACK   = ack_q;
   assign LOCAL_RDATA = rdata_q;
   assign LOCAL_RESP  = resp_q;
endmodule

// File: tb/tb_aq_axilm_bridge.sv
// Bench for aq_axilm_bridge: delay-configurable register slave, vector table, random traffic and reset/back-to-back sequences.
module tb_aq_axilm_bridge;
   localparam int unsigned ADDR_W = 32;
   localparam logic [31:0] OVR_DATA = 32'h1234_5678;

   logic              clk;
   logic              ARESETN;
   logic              LOCAL_REQ;
   logic              LOCAL_RNW;
   logic [ADDR_W-1:0] LOCAL_ADDR;
   logic [3:0]        LOCAL_BE;
   logic [31:0]       LOCAL_WDATA;
   logic              LOCAL_BUSY;
   logic              LOCAL_ACK;
   logic [31:0]       LOCAL_RDATA;
   logic [1:0]        LOCAL_RESP;

   aq_axilm_bridge_if #(.ADDR_W(ADDR_W)) axi ();

   aq_axilm_bridge #(.ADDR_W(ADDR_W)) dut (
      .ACLK        (clk),
      .ARESETN     (ARESETN),
      .LOCAL_REQ   (LOCAL_REQ),
      .LOCAL_RNW   (LOCAL_RNW),
      .LOCAL_ADDR  (LOCAL_ADDR),
      .LOCAL_BE    (LOCAL_BE),
      .LOCAL_WDATA (LOCAL_WDATA),
      .LOCAL_BUSY  (LOCAL_BUSY),
      .LOCAL_ACK   (LOCAL_ACK),
      .LOCAL_RDATA (LOCAL_RDATA),
      .LOCAL_RESP  (LOCAL_RESP),
      .m_axi       (axi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rnw;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          daw, dw, db, dar, dr;
      logic [1:0]  bresp, rresp;
      bit          rovr;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_lat;
   } vec_t;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Slave configuration for the transaction in flight
   int          cfg_daw, cfg_dw, cfg_db, cfg_dar, cfg_dr;
   logic [1:0]  cfg_bresp, cfg_rresp;
   bit          cfg_rovr;

   logic [31:0] slave_mem [16];
   logic [31:0] ref_mem [16];
   logic [31:0] ref_last_rdata;

   // Monitor state (sampled at rising edges)
   bit          aw_fire, w_fire, b_fire, ar_fire, r_fire;
   int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
   int          awv_cyc, wv_cyc, arv_cyc;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   initial begin
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      awv_cyc = 0; wv_cyc = 0; arv_cyc = 0;
      cap_awaddr = '0; cap_wdata = '0; cap_araddr = '0; cap_wstrb = '0;
      forever begin
         @(posedge clk);
         if (!ARESETN) begin
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
         end else begin
            aw_fire = axi.awvalid && axi.awready;
            w_fire  = axi.wvalid && axi.wready;
            b_fire  = axi.bvalid && axi.bready;
            ar_fire = axi.arvalid && axi.arready;
            r_fire  = axi.rvalid && axi.rready;
            if (axi.awvalid) awv_cyc++;
            if (axi.wvalid)  wv_cyc++;
            if (axi.arvalid) arv_cyc++;
            if (aw_fire) begin aw_hs++; cap_awaddr = axi.awaddr; end
            if (w_fire)  begin w_hs++; cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; end
            if (b_fire)  b_hs++;
            if (ar_fire) begin ar_hs++; cap_araddr = axi.araddr; end
            if (r_fire)  r_hs++;
         end
      end
   end

   // Register slave: drives ready/response signals on falling edges with configurable wait cycles.
   initial begin
      int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
      bit  aw_got, w_got, ar_got;
      logic [3:0] widx;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
      axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00;
      forever begin
         @(negedge clk);
         if (!ARESETN) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
            axi.arready = 0; axi.rvalid = 0;
         end else begin
            if (aw_fire) begin axi.awready = 0; aw_cnt = 0; aw_got = 1; end
            else if (axi.awvalid && !axi.awready) begin
               if (aw_cnt >= cfg_daw) axi.awready = 1; else aw_cnt++;
            end
            if (w_fire) begin axi.wready = 0; w_cnt = 0; w_got = 1; end
            else if (axi.wvalid && !axi.wready) begin
               if (w_cnt >= cfg_dw) axi.wready = 1; else w_cnt++;
            end
            if (ar_fire) begin axi.arready = 0; ar_cnt = 0; ar_got = 1; end
            else if (axi.arvalid && !axi.arready) begin
               if (ar_cnt >= cfg_dar) axi.arready = 1; else ar_cnt++;
            end
            if (b_fire) axi.bvalid = 0;
            else if (aw_got && w_got && !axi.bvalid) begin
               if (b_cnt >= cfg_db) begin
                  widx = cap_awaddr[5:2];
                  for (int b = 0; b < 4; b++)
                     if (cap_wstrb[b]) slave_mem[widx][8*b +: 8] = cap_wdata[8*b +: 8];
                  axi.bvalid = 1; axi.bresp = cfg_bresp;
                  aw_got = 0; w_got = 0; b_cnt = 0;
               end else b_cnt++;
            end
            if (r_fire) axi.rvalid = 0;
            else if (ar_got && !axi.rvalid) begin
               if (r_cnt >= cfg_dr) begin
                  axi.rdata  = cfg_rovr ? OVR_DATA : slave_mem[cap_araddr[5:2]];
                  axi.rresp  = cfg_rresp;
                  axi.rvalid = 1; ar_got = 0; r_cnt = 0;
               end else r_cnt++;
            end
         end
      end
   end

   // Reference model: word memory with byte strobes, latency from slave wait counts.
   task automatic ref_apply(input vec_t v, output logic [31:0] er, output logic [1:0] eresp, output int elat);
      logic [3:0] idx;
      idx = v.addr[5:2];
      if (!v.rnw) begin
         for (int b = 0; b < 4; b++)
            if (v.be[b]) ref_mem[idx][8*b +: 8] = v.wdata[8*b +: 8];
         er    = ref_last_rdata;
         eresp = v.bresp;
         elat  = 2 + ((v.daw > v.dw) ? v.daw : v.dw) + v.db;
      end else begin
         er    = v.rovr ? OVR_DATA : ref_mem[idx];
         ref_last_rdata = er;
         eresp = v.rresp;
         elat  = 2 + v.dar + v.dr;
      end
   endtask

   function automatic vec_t mkv(bit rnw, logic [31:0] addr, logic [3:0] be, logic [31:0] wdata,
                                int daw, int dw, int db, int dar, int dr,
                                logic [1:0] bresp, logic [1:0] rresp, bit rovr,
                                logic [31:0] exp_rdata, logic [1:0] exp_resp, int exp_lat);
      vec_t v;
      v.rnw = rnw; v.addr = addr; v.be = be; v.wdata = wdata;
      v.daw = daw; v.dw = dw; v.db = db; v.dar = dar; v.dr = dr;
      v.bresp = bresp; v.rresp = rresp; v.rovr = rovr;
      v.exp_rdata = exp_rdata; v.exp_resp = exp_resp; v.exp_lat = exp_lat;
      return v;
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      int aw0, w0, b0, ar0, r0, awc0, wc0, arc0, lat;
      bit bad_busy, bad_bready;
      cfg_daw = v.daw; cfg_dw = v.dw; cfg_db = v.db; cfg_dar = v.dar; cfg_dr = v.dr;
      cfg_bresp = v.bresp; cfg_rresp = v.rresp; cfg_rovr = v.rovr;
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
      awc0 = awv_cyc; wc0 = wv_cyc; arc0 = arv_cyc;
      @(negedge clk);
      LOCAL_REQ = 1; LOCAL_RNW = v.rnw; LOCAL_ADDR = v.addr; LOCAL_BE = v.be; LOCAL_WDATA = v.wdata;
      @(negedge clk);
      LOCAL_REQ = 0;
      if (v.rnw) chk({tag, ":arvalid_e1"}, 32'(axi.arvalid), 32'd1);
      else       chk({tag, ":aw_w_valid_e1"}, 32'({axi.awvalid, axi.wvalid}), 32'd3);
      chk({tag, ":busy_e1"}, 32'(LOCAL_BUSY), 32'd1);
      bad_busy = 0; bad_bready = 0; lat = -1;
      for (int n = 1; n <= 64; n++) begin
         @(negedge clk);
         if (LOCAL_ACK) begin lat = n; break; end
         if (!LOCAL_BUSY) bad_busy = 1;
         if (axi.bready && (aw_hs == aw0 || w_hs == w0)) bad_bready = 1;
      end
      if (lat < 0) begin
         total_cnt++;
         $display("FAIL %s:timeout got no LOCAL_ACK required ack within 64 cycles", tag);
      end else begin
         chk({tag, ":latency"}, 32'(lat), 32'(v.exp_lat));
         chk({tag, ":busy_at_ack"}, 32'(LOCAL_BUSY), 32'd0);
         chk({tag, ":rdata"}, LOCAL_RDATA, v.exp_rdata);
         chk({tag, ":resp"}, 32'(LOCAL_RESP), 32'(v.exp_resp));
         chk({tag, ":busy_held"}, 32'(bad_busy), 32'd0);
         chk({tag, ":bready_order"}, 32'(bad_bready), 32'd0);
         if (!v.rnw) begin
            chk({tag, ":hs_aw_w_b_ar"}, {8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0), 8'(ar_hs - ar0)}, 32'h0101_0100);
            chk({tag, ":awvalid_cycles"}, 32'(awv_cyc - awc0), 32'(v.daw + 1));
            chk({tag, ":wvalid_cycles"}, 32'(wv_cyc - wc0), 32'(v.dw + 1));
            chk({tag, ":awaddr"}, cap_awaddr, v.addr);
            chk({tag, ":wdata"}, cap_wdata, v.wdata);
            chk({tag, ":wstrb"}, 32'(cap_wstrb), 32'(v.be));
         end else begin
            chk({tag, ":hs_ar_r_aw"}, {8'(ar_hs - ar0), 8'(r_hs - r0), 8'(aw_hs - aw0), 8'h0}, 32'h0101_0000);
            chk({tag, ":arvalid_cycles"}, 32'(arv_cyc - arc0), 32'(v.dar + 1));
            chk({tag, ":araddr"}, cap_araddr, v.addr);
         end
         @(negedge clk);
         chk({tag, ":ack_one_cycle"}, 32'(LOCAL_ACK), 32'd0);
      end
   endtask

   initial begin
      vec_t        tbl [11];
      vec_t        v;
      logic [31:0] er;
      logic [1:0]  eresp;
      int          elat, aw0, ar0, lat;

      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [11];
      vec_t        v;
      logic [31:0] er;
      logic [1:0]  eresp;
      int          elat, aw0, ar0, lat;

      for (int i = 0; i < 16; i++) begin slave_mem[i] = '0; ref_mem[i] = '0; end
      ref_last_rdata = '0;
      cfg_daw = 0; cfg_dw = 0; cfg_db = 0; cfg_dar = 0; cfg_dr = 0;
      cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rovr = 0;
      LOCAL_REQ = 0; LOCAL_RNW = 0; LOCAL_ADDR = '0; LOCAL_BE = '0; LOCAL_WDATA = '0;

      //            rnw addr    be     wdata          daw dw db dar dr bresp rresp ovr exp_rdata     resp  lat
      tbl[0]  = mkv(0, 32'h04, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 32'h0,         2'd0, 2);
      tbl[1]  = mkv(1, 32'h04, 4'h0, 32'h0,         0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 32'hDEAD_BEEF, 2'd0, 2);
      tbl[2]  = mkv(1, 32'h10, 4'h0, 32'h0,         0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 32'h0,         2'd0, 2);
      tbl[3]  = mkv(0, 32'h08, 4'hF, 32'hA5A5_A5A5, 0, 3, 0, 0, 0, 2'd0, 2'd0, 0, 32'h0,         2'd0, 5);
      tbl[4]  = mkv(0, 32'h0C, 4'hF, 32'h1122_3344, 3, 0, 0, 0, 0, 2'd0, 2'd0, 0, 32'h0,         2'd0, 5);
      tbl[5]  = mkv(0, 32'h08, 4'h3, 32'hFFFF_0000, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 32'h0,         2'd0, 2);
      tbl[6]  = mkv(1, 32'h08, 4'h0, 32'h0,         0, 0, 0, 2, 1, 2'd0, 2'd0, 0, 32'hA5A5_0000, 2'd0, 5);
      tbl[7]  = mkv(0, 32'h14, 4'hF, 32'hCAFE_F00D, 0, 0, 2, 0, 0, 2'd2, 2'd0, 0, 32'hA5A5_0000, 2'd2, 4);
      tbl[8]  = mkv(1, 32'h0C, 4'h0, 32'h0,         0, 0, 0, 0, 0, 2'd0, 2'd3, 1, 32'h1234_5678, 2'd3, 2);
      tbl[9]  = mkv(0, 32'h18, 4'h8, 32'h0102_0304, 1, 2, 1, 0, 0, 2'd0, 2'd0, 0, 32'h1234_5678, 2'd0, 5);
      tbl[10] = mkv(1, 32'h18, 4'h0, 32'h0,         0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 32'h0100_0000, 2'd0, 2);

      ARESETN = 0;
      repeat (3) @(negedge clk);
      chk("reset:busy_ack", 32'({LOCAL_BUSY, LOCAL_ACK}), 32'd0);
      chk("reset:valids_readies", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
      chk("reset:rdata", LOCAL_RDATA, 32'h0);
      chk("reset:resp_addr", 32'(LOCAL_RESP) | axi.awaddr | axi.araddr, 32'h0);
      ARESETN = 1;
      @(negedge clk);
      chk("const:cache_prot", {8'(axi.awcache), 8'(axi.awprot), 8'(axi.arcache), 8'(axi.arprot)}, 32'h0300_0300);

      foreach (tbl[i]) begin
         ref_apply(tbl[i], er, eresp, elat);
         run_txn(tbl[i], $sformatf("vec%0d", i));
      end

      // Randomized traffic checked against the reference model
      for (int k = 0; k < 40; k++) begin
         v.rnw   = 1'($urandom_range(0, 1));
         v.addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         v.be    = 4'($urandom);
         v.wdata = $urandom;
         v.daw = $urandom_range(0, 3); v.dw = $urandom_range(0, 3); v.db = $urandom_range(0, 2);
         v.dar = $urandom_range(0, 3); v.dr = $urandom_range(0, 2);
         v.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         v.rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         v.rovr  = 0;
         ref_apply(v, er, eresp, elat);
         v.exp_rdata = er; v.exp_resp = eresp; v.exp_lat = elat;
         run_txn(v, $sformatf("rnd%0d", k));
      end

      // Back-to-back: new request on the ACK cycle, extra pulses while busy are dropped
      cfg_daw = 0; cfg_dw = 0; cfg_db = 0; cfg_dar = 0; cfg_dr = 0;
      cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rovr = 0;
      aw0 = aw_hs; ar0 = ar_hs;
      @(negedge clk);
      LOCAL_REQ = 1; LOCAL_RNW = 0; LOCAL_ADDR = 32'h1C; LOCAL_BE = 4'hF; LOCAL_WDATA = 32'h55AA_55AA;
      @(negedge clk);
      LOCAL_RNW = 1; LOCAL_ADDR = 32'h3C;
      @(negedge clk);
      @(negedge clk);
      chk("b2b:first_ack", 32'(LOCAL_ACK), 32'd1);
      LOCAL_REQ = 1; LOCAL_RNW = 1; LOCAL_ADDR = 32'h1C;
      @(negedge clk);
      LOCAL_REQ = 0;
      chk("b2b:arvalid_next", 32'({axi.arvalid, LOCAL_BUSY}), 32'd3);
      lat = -1;
      for (int n = 1; n <= 64; n++) begin
         @(negedge clk);
         if (LOCAL_ACK) begin lat = n; break; end
      end
      chk("b2b:read_lat", 32'(lat), 32'd2);
      chk("b2b:rdata", LOCAL_RDATA, 32'h55AA_55AA);
      chk("b2b:hs_counts", {16'(aw_hs - aw0), 16'(ar_hs - ar0)}, 32'h0001_0001);
      chk("b2b:araddr", cap_araddr, 32'h1C);
      ref_mem[7] = 32'h55AA_55AA;
      ref_last_rdata = 32'h55AA_55AA;

      // Async reset while a write is stalled in the address phase
      cfg_daw = 1000; cfg_dw = 1000;
      @(negedge clk);
      LOCAL_REQ = 1; LOCAL_RNW = 0; LOCAL_ADDR = 32'h20; LOCAL_BE = 4'hF; LOCAL_WDATA = 32'h7777_7777;
      @(negedge clk);
      LOCAL_REQ = 0;
      @(negedge clk);
      chk("rst_mid:awvalid_pre", 32'({axi.awvalid, LOCAL_BUSY}), 32'd3);
      ARESETN = 0;
      #1;
      chk("rst_mid:valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
      chk("rst_mid:busy_ack", 32'({LOCAL_BUSY, LOCAL_ACK}), 32'd0);
      chk("rst_mid:addr_rdata", axi.awaddr | LOCAL_RDATA, 32'h0);
      repeat (2) @(negedge clk);
      ARESETN = 1;
      cfg_daw = 0; cfg_dw = 0;
      ref_last_rdata = '0;
      v = mkv(1, 32'h04, 4'h0, 32'h0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0, 32'h0, 2'd0, 0);
      ref_apply(v, er, eresp, elat);
      v.exp_rdata = er; v.exp_resp = eresp; v.exp_lat = elat;
      run_txn(v, "post_reset_read");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
